// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: core (m0) and debug/loader (m1) share one memory.
// Optional round-robin tie-break via MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic            last_port;
  logic            rv0_q;
  logic            rv1_q;
  logic [31:0]     a_q;
  logic [31:0]     wd_q;
  logic            g0;
  logic            g1;
  logic            hit0;
  logic            hit1;
  logic            tie1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic            rr_ptr;
  assign tie1 = rr_ptr;
`else
  assign tie1 = 1'b0;
`endif

  // Hold limit reached by the port that won the recent run of grants.
  assign hit0 = !last_port && m1_req &&
                (hold_cnt == CW'(MAX_HOLD));
  assign hit1 = last_port && m0_req &&
                (hold_cnt == CW'(MAX_HOLD));

  // Grant decision from current requests and ownership state.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (m0_req && m1_req) begin
            if (hit0)      g1 = 1'b1;
            else if (hit1) g0 = 1'b1;
            else if (tie1) g1 = 1'b1;
            else           g0 = 1'b1;
          end else begin
            g0 = m0_req;
            g1 = m1_req;
          end
        end
        OWN0: begin
          if (m0_req && !hit0) g0 = 1'b1;
          else                 g1 = m1_req;
        end
        OWN1: begin
          if (m1_req && !hit1) g1 = 1'b1;
          else                 g0 = m0_req;
        end
        default: begin
          g0 = 1'b0;
          g1 = 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt = g0;
  assign m1_gnt = g1;

  assign mem_we = (g0 & m0_we) | (g1 & m1_we);
  assign mem_a  = reset ? '0 :
                  g0 ? m0_addr :
                  g1 ? m1_addr : a_q;
  assign mem_wd = reset ? '0 :
                  g0 ? m0_wdata :
                  g1 ? m1_wdata : wd_q;

  assign m0_rvalid = rv0_q & ~reset;
  assign m1_rvalid = rv1_q & ~reset;
  assign m0_rdata  = m0_rvalid ? mem_rd : '0;
  assign m1_rdata  = m1_rvalid ? mem_rd : '0;

  // Ownership FSM, hold counter, read tags and held bus values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_port <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      a_q       <= '0;
      wd_q      <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      rv0_q <= g0 & ~m0_we;
      rv1_q <= g1 & ~m1_we;
      if (g0 || g1) begin
        a_q       <= mem_a;
        wd_q      <= mem_wd;
        last_port <= g1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        rr_ptr    <= ~g1;
`endif
      end
      if (g0)
        state <= m0_lock ? OWN0 : IDLE;
      else if (g1)
        state <= m1_lock ? OWN1 : IDLE;
      else
        state <= IDLE;
      if (g0 && m1_req)
        hold_cnt <= !last_port ?
                    hold_cnt + CW'(1) : CW'(1);
      else if (g1 && m0_req)
        hold_cnt <= last_port ?
                    hold_cnt + CW'(1) : CW'(1);
      else
        hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected cycles,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [64];

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        rst;
    logic        g0;
    logic        g1;
    logic        we;
    logic [31:0] a;
    logic        rv0;
    logic        rv1;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;
  logic [31:0] pend_rd = '0;
  logic [31:0] exp_last_a = '0;

  mem_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the address cycle.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[1] <= 32'h1111_1104;
      mem[2] <= 32'h2222_2208;
      mem[4] <= 32'hDEAD_BEEF;
      mem_rd <= '0;
    end else begin
      if (mem_we) mem[mem_a[7:2]] <= mem_wd;
      mem_rd <= mem[mem_a[7:2]];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: compare one expected record per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, e.g0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, e.g1});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
      chk("mem_a", mem_a, e.a);
      chk("m0_rvalid", {31'b0, m0_rvalid},
          {31'b0, e.rv0});
      chk("m1_rvalid", {31'b0, m1_rvalid},
          {31'b0, e.rv1});
      if (e.rv0) chk("m0_rdata", m0_rdata, e.rd);
      if (e.rv1) chk("m1_rdata", m1_rdata, e.rd);
      if (e.rst) begin
        chk("mem_wd_rst", mem_wd, 32'h0);
        chk("m0_rdata_rst", m0_rdata, 32'h0);
        chk("m1_rdata_rst", m1_rdata, 32'h0);
      end
    end
  end

  task automatic cyc(
    input logic        rst,
    input logic        r0, w0, l0,
    input logic [31:0] a0,
    input logic        r1, w1, l1,
    input logic [31:0] a1,
    input logic [31:0] wd,
    input logic        eg0, eg1,
    input logic [31:0] erd);
    exp_t e;
    reset    = rst;
    m0_req   = r0;
    m0_we    = w0;
    m0_lock  = l0;
    m0_addr  = a0;
    m0_wdata = wd;
    m1_req   = r1;
    m1_we    = w1;
    m1_lock  = l1;
    m1_addr  = a1;
    m1_wdata = wd;
    if (rst)      exp_last_a = '0;
    else if (eg0) exp_last_a = a0;
    else if (eg1) exp_last_a = a1;
    e.rst = rst;
    e.g0  = eg0;
    e.g1  = eg1;
    e.we  = (eg0 & w0) | (eg1 & w1);
    e.a   = exp_last_a;
    e.rv0 = !rst && pend0;
    e.rv1 = !rst && pend1;
    e.rd  = pend_rd;
    pend0   = !rst && eg0 && !w0;
    pend1   = !rst && eg1 && !w1;
    pend_rd = erd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0,0,0,0, 0,0,0,0, 0, 0,0, 0);
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0;
    m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0;
    m1_addr = 0; m1_wdata = 0;
    @(posedge clk);
    #1;

    // Reset held with both requesting.
    repeat (3)
      cyc(1, 1,0,0,32'h10, 1,0,0,32'h8, 0, 0,0, 0);
    // First cycle out of reset: m0 read of 0x10.
    cyc(0, 1,0,0,32'h10, 1,0,0,32'h8, 0,
        1,0, 32'hDEAD_BEEF);
    idle();

    // Both requesting, no lock, four cycles.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        cyc(0, 1,0,0,32'h4, 1,0,0,32'h8, 0,
            0,1, 32'h2222_2208);
      else
        cyc(0, 1,0,0,32'h4, 1,0,0,32'h8, 0,
            1,0, 32'h1111_1104);
    end
`else
    repeat (4)
      cyc(0, 1,0,0,32'h4, 1,0,0,32'h8, 0,
          1,0, 32'h1111_1104);
`endif
    idle();

    // Alternating single reads: m0 at 0x4, m1 at 0x8.
    cyc(0, 1,0,0,32'h4, 0,0,0,32'h0, 0,
        1,0, 32'h1111_1104);
    cyc(0, 0,0,0,32'h0, 1,0,0,32'h8, 0,
        0,1, 32'h2222_2208);
    idle();

    // m1 writes 0x55 to 0x20, m0 reads it back.
    cyc(0, 0,0,0,32'h0, 1,1,0,32'h20, 32'h55,
        0,1, 0);
    cyc(0, 1,0,0,32'h20, 0,0,0,32'h0, 0,
        1,0, 32'h55);
    idle();
    idle();

    // Lock with contention: m1 prime, then 8 m0, then m1.
    cyc(0, 0,0,0,32'h0, 1,0,0,32'h8, 0,
        0,1, 32'h2222_2208);
    repeat (8)
      cyc(0, 1,0,1,32'h10, 1,0,0,32'h8, 0,
          1,0, 32'hDEAD_BEEF);
    cyc(0, 1,0,1,32'h10, 1,0,0,32'h8, 0,
        0,1, 32'h2222_2208);
    idle();

    // Reset right after a read grant drops its rvalid.
    cyc(0, 1,0,0,32'h4, 0,0,0,32'h0, 0,
        1,0, 32'h1111_1104);
    cyc(1, 0,0,0,32'h0, 0,0,0,32'h0, 0,
        0,0, 0);
    idle();
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d records left, 0 required",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
